// File: rtl/rsa_pkg.sv
// Shared types and elaboration helpers for the RSA modular-exponentiation engine.
package rsa_pkg;

  // Top-level sequencing states of the square-and-always-multiply ladder.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHECK     = 3'd1,
    TO_MONT   = 3'd2,
    SQR       = 3'd3,
    MUL       = 3'd4,
    FROM_MONT = 3'd5,
    DONE      = 3'd6
  } state_e;

  // Internal phases of one Montgomery multiplication.
  typedef enum logic [1:0] {
    MM_IDLE = 2'd0,
    MM_RUN  = 2'd1,
    MM_SUB  = 2'd2
  } mm_phase_e;

  // Number of radix-2^logr digit iterations in one Montgomery multiply.
  function automatic int num_digits(input int n_bit, input int logr);
    return n_bit / logr;
  endfunction

  // Legal configuration: digits tile the modulus, modulus odd and in range.
  function automatic bit cfg_ok(input int n_bit, input int n, input int logr);
    if (logr <= 32'sd0) begin
      return 1'b0;
    end else begin
      return ((n_bit % logr) == 32'sd0) && ((n % 32'sd2) == 32'sd1) &&
             (n > 32'sd0) && (n < (32'sd1 <<< n_bit));
    end
  endfunction

  // Digit count for the default 7-bit, radix-2 configuration.
  localparam int DEF_K = num_digits(32'sd7, 32'sd1);

endpackage

// File: rtl/rsa_mont_mul.sv
// Radix-2^LOGR Montgomery multiplier: res = a*b*R^-1 mod N, fixed K+2 cycle latency.
// Inputs a and b must both be below N; the result is always below N.
module rsa_mont_mul
  import rsa_pkg::*;
#(
  parameter int N_BIT = 7,
  parameter int N = 79,
  parameter int LOGR = 1,
  parameter logic [LOGR-1:0] P = LOGR'(1'b1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [N_BIT-1:0] a,
  input  logic [N_BIT-1:0] b,
  output logic [N_BIT-1:0] res,
  output logic             rdy
);

  localparam int K = num_digits(N_BIT, LOGR);
  localparam int TW = N_BIT + LOGR + 1;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [TW-1:0] N_T = TW'(N);
  localparam logic [CW-1:0] K_LAST = CW'(K - 1);

  mm_phase_e        phase_r;
  logic [CW-1:0]    cnt_r;
  logic [N_BIT-1:0] a_r;
  logic [N_BIT-1:0] b_r;
  logic [TW-1:0]    t_r;
  logic [N_BIT-1:0] res_r;
  logic             rdy_r;

  logic [LOGR-1:0]  a_dig_s;
  logic [LOGR-1:0]  u_s;
  logic [TW-1:0]    sum1_s;
  logic [TW-1:0]    sum2_s;
  logic [TW-1:0]    t_next_s;

  // One digit step: add a_i*b, pick u to clear the low digit, add u*N, shift out.
  always_comb begin
    a_dig_s  = a_r[LOGR-1:0];
    sum1_s   = t_r + (TW'(a_dig_s) * TW'(b_r));
    u_s      = sum1_s[LOGR-1:0] * P;
    sum2_s   = sum1_s + (TW'(u_s) * N_T);
    t_next_s = sum2_s >> LOGR;
  end

  // Load, iterate K digits, then one conditional subtract producing res/rdy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r <= MM_IDLE;
      cnt_r   <= {CW{1'b0}};
      a_r     <= {N_BIT{1'b0}};
      b_r     <= {N_BIT{1'b0}};
      t_r     <= {TW{1'b0}};
      res_r   <= {N_BIT{1'b0}};
      rdy_r   <= 1'b0;
    end else begin
      rdy_r <= 1'b0;
      case (phase_r)
        MM_IDLE: begin
          if (go) begin
            a_r     <= a;
            b_r     <= b;
            t_r     <= {TW{1'b0}};
            cnt_r   <= {CW{1'b0}};
            phase_r <= MM_RUN;
          end else begin
            phase_r <= MM_IDLE;
          end
        end
        MM_RUN: begin
          t_r <= t_next_s;
          a_r <= a_r >> LOGR;
          if (cnt_r == K_LAST) begin
            phase_r <= MM_SUB;
          end else begin
            cnt_r <= cnt_r + CW'(1'b1);
          end
        end
        MM_SUB: begin
          res_r   <= N_BIT'((t_r >= N_T) ? (t_r - N_T) : t_r);
          rdy_r   <= 1'b1;
          phase_r <= MM_IDLE;
        end
        default: begin
          phase_r <= MM_IDLE;
        end
      endcase
    end
  end

  assign res = res_r;
  assign rdy = rdy_r;

endmodule

// File: rtl/rsa_modexp_engine.sv
// Constant-time RSA modular exponentiation: data_out = data_in^exp_in mod N.
// Montgomery-domain square-and-always-multiply ladder; every multiply is issued
// in the same cycle the previous one reports rdy, so latency is exponent-independent.
module rsa_modexp_engine
  import rsa_pkg::*;
#(
  parameter int N_BIT = 7,
  parameter int N = 79,
  parameter int LOGR = 1,
  parameter logic [LOGR-1:0] P = LOGR'(1'b1),
  parameter int RMODN = 49,
  parameter int R2MODN = 31,
  parameter int E_BIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N_BIT-1:0] data_in,
  input  logic [E_BIT-1:0] exp_in,
  output logic [N_BIT-1:0] data_out,
  output logic             done,
  output logic             busy,
  output logic             err
);

  localparam int BW = (E_BIT > 1) ? $clog2(E_BIT) : 1;
  localparam logic [BW-1:0]    BIT_TOP  = BW'(E_BIT - 1);
  localparam logic [N_BIT-1:0] N_V      = N_BIT'(N);
  localparam logic [N_BIT-1:0] RMODN_V  = N_BIT'(RMODN);
  localparam logic [N_BIT-1:0] R2MODN_V = N_BIT'(R2MODN);
  localparam logic [N_BIT-1:0] ONE_V    = N_BIT'(1);

  if (!cfg_ok(N_BIT, N, LOGR)) begin : g_cfg_bad
    $error("rsa_modexp_engine: N_BIT must be a multiple of LOGR and N must be odd and below 2^N_BIT");
  end

  state_e           state_r;
  state_e           state_nxt_s;
  logic [N_BIT-1:0] x_r;
  logic [E_BIT-1:0] exp_r;
  logic [BW-1:0]    bit_r;
  logic [N_BIT-1:0] acc_r;
  logic [N_BIT-1:0] base_m_r;
  logic [N_BIT-1:0] data_out_r;
  logic             done_r;
  logic             busy_r;
  logic             err_r;

  logic             go_s;
  logic [N_BIT-1:0] op_a_s;
  logic [N_BIT-1:0] op_b_s;
  logic [N_BIT-1:0] mul_acc_s;
  logic [N_BIT-1:0] mm_res_s;
  logic             mm_rdy_s;

  rsa_mont_mul #(
    .N_BIT (N_BIT),
    .N     (N),
    .LOGR  (LOGR),
    .P     (P)
  ) u_mont_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .go    (go_s),
    .a     (op_a_s),
    .b     (op_b_s),
    .res   (mm_res_s),
    .rdy   (mm_rdy_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and multiplier operand selection; the next multiply is chained on rdy.
  always_comb begin
    state_nxt_s = state_r;
    go_s        = 1'b0;
    op_a_s      = acc_r;
    op_b_s      = acc_r;
    mul_acc_s   = exp_r[bit_r] ? mm_res_s : acc_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = CHECK;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CHECK: begin
        if (x_r >= N_V) begin
          state_nxt_s = DONE;
        end else begin
          go_s        = 1'b1;
          op_a_s      = x_r;
          op_b_s      = R2MODN_V;
          state_nxt_s = TO_MONT;
        end
      end
      TO_MONT: begin
        if (mm_rdy_s) begin
          go_s        = 1'b1;
          op_a_s      = acc_r;
          op_b_s      = acc_r;
          state_nxt_s = SQR;
        end else begin
          state_nxt_s = TO_MONT;
        end
      end
      SQR: begin
        if (mm_rdy_s) begin
          go_s        = 1'b1;
          op_a_s      = mm_res_s;
          op_b_s      = base_m_r;
          state_nxt_s = MUL;
        end else begin
          state_nxt_s = SQR;
        end
      end
      MUL: begin
        if (mm_rdy_s) begin
          go_s   = 1'b1;
          op_a_s = mul_acc_s;
          if (bit_r == {BW{1'b0}}) begin
            op_b_s      = ONE_V;
            state_nxt_s = FROM_MONT;
          end else begin
            op_b_s      = mul_acc_s;
            state_nxt_s = SQR;
          end
        end else begin
          state_nxt_s = MUL;
        end
      end
      FROM_MONT: begin
        if (mm_rdy_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = FROM_MONT;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Operand capture, ladder accumulator, bit counter and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r        <= {N_BIT{1'b0}};
      exp_r      <= {E_BIT{1'b0}};
      bit_r      <= {BW{1'b0}};
      acc_r      <= {N_BIT{1'b0}};
      base_m_r   <= {N_BIT{1'b0}};
      data_out_r <= {N_BIT{1'b0}};
      err_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            x_r   <= data_in;
            exp_r <= exp_in;
            bit_r <= BIT_TOP;
            err_r <= 1'b0;
          end
        end
        CHECK: begin
          if (x_r >= N_V) begin
            err_r      <= 1'b1;
            data_out_r <= {N_BIT{1'b0}};
          end else begin
            acc_r <= RMODN_V;
          end
        end
        TO_MONT: begin
          if (mm_rdy_s) begin
            base_m_r <= mm_res_s;
          end
        end
        SQR: begin
          if (mm_rdy_s) begin
            acc_r <= mm_res_s;
          end
        end
        MUL: begin
          if (mm_rdy_s) begin
            acc_r <= mul_acc_s;
            if (bit_r != {BW{1'b0}}) begin
              bit_r <= bit_r - BW'(1'b1);
            end
          end
        end
        FROM_MONT: begin
          if (mm_rdy_s) begin
            data_out_r <= mm_res_s;
          end
        end
        default: begin
          err_r <= err_r;
        end
      endcase
    end
  end

  // Registered status flags derived from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_r <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      done_r <= (state_nxt_s == DONE);
      busy_r <= (state_nxt_s != IDLE);
    end
  end

  assign data_out = data_out_r;
  assign done     = done_r;
  assign busy     = busy_r;
  assign err      = err_r;

endmodule

// File: tb/tb_rsa_modexp_engine.sv
// Directed bench for rsa_modexp_engine: radix-2 and radix-128 instances side by side.
module tb_rsa_modexp_engine;

  localparam int LAT1 = 164;  // 2 + 18 multiplies * 9 cycles
  localparam int LAT7 = 56;   // 2 + 18 multiplies * 3 cycles
  localparam int LATE = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start1 = 1'b0;
  logic       start7 = 1'b0;
  logic [6:0] data_in = 7'd0;
  logic [7:0] exp_in = 8'd0;
  logic [6:0] data_out1, data_out7;
  logic       done1, busy1, err1, done7, busy7, err7;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rsa_modexp_engine u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .data_in(data_in), .exp_in(exp_in),
    .data_out(data_out1), .done(done1), .busy(busy1), .err(err1)
  );

  rsa_modexp_engine #(.LOGR(7), .P(7'd81)) u_dut7 (
    .clk(clk), .rst_n(rst_n), .start(start7), .data_in(data_in), .exp_in(exp_in),
    .data_out(data_out7), .done(done7), .busy(busy7), .err(err7)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_pow(input int b, input int e);
    int r;
    r = 1;
    for (int i = 7; i >= 0; i--) begin
      r = (r * r) % 79;
      if (e[i]) r = (r * b) % 79;
    end
    return r;
  endfunction

  // Start both engines, find each done pulse and check result, err and latency.
  task automatic do_op(input string tag, input int d, input int e, input int exp_out, input int exp_err);
    int n, lat1, lat7, r1, r7, e1, e7, b1;
    lat1 = 0; lat7 = 0; r1 = -1; r7 = -1; e1 = -1; e7 = -1; b1 = -1;
    @(negedge clk);
    start1 = 1'b1; start7 = 1'b1; data_in = 7'(d); exp_in = 8'(e);
    @(negedge clk);
    start1 = 1'b0; start7 = 1'b0; data_in = ~7'(d); exp_in = ~8'(e);
    check_eq({tag, "/busy_at_accept"}, int'(busy1), 1);
    for (n = 1; n <= 400 && (lat1 == 0 || lat7 == 0); n++) begin
      if (n > 1) @(negedge clk);
      if (done1 && lat1 == 0) begin
        lat1 = n; r1 = int'(data_out1); e1 = int'(err1); b1 = int'(busy1);
      end
      if (done7 && lat7 == 0) begin
        lat7 = n; r7 = int'(data_out7); e7 = int'(err7);
      end
    end
    check_eq({tag, "/lat_r2"}, lat1, (exp_err != 0) ? LATE : LAT1);
    check_eq({tag, "/out_r2"}, r1, exp_out);
    check_eq({tag, "/err_r2"}, e1, exp_err);
    check_eq({tag, "/busy_at_done"}, b1, 1);
    check_eq({tag, "/lat_r128"}, lat7, (exp_err != 0) ? LATE : LAT7);
    check_eq({tag, "/out_r128"}, r7, exp_out);
    check_eq({tag, "/err_r128"}, e7, exp_err);
  endtask

  initial begin
    int dones, lat_a, lat_b, r_a, r_b, busy_gap, c;

    // Asynchronous reset values
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst/data_out", int'(data_out1), 0);
    check_eq("rst/done", int'(done1), 0);
    check_eq("rst/busy", int'(busy1), 0);
    check_eq("rst/err", int'(err1), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors (values computed by hand mod 79)
    do_op("enc_20_5", 20, 5, 26, 0);
    do_op("dec_26_47", 26, 47, 20, 0);
    do_op("exp0", 20, 0, 1, 0);
    do_op("zero_base", 0, 5, 0, 0);
    do_op("nm1_exp1", 78, 1, 78, 0);
    do_op("bad_80", 80, 5, 0, 1);
    do_op("enc_again", 20, 5, 26, 0);
    do_op("bad_eq_n", 79, 5, 0, 1);
    do_op("bad_127", 127, 47, 0, 1);
    do_op("nm1_exp2", 78, 2, 1, 0);

    // Start pulses while busy must be ignored (radix-2 engine only)
    @(negedge clk);
    start1 = 1'b1; data_in = 7'd20; exp_in = 8'd5;
    @(negedge clk);
    start1 = 1'b0; data_in = 7'd0; exp_in = 8'd0;
    dones = 0; lat_a = 0; r_a = -1;
    for (int n = 1; n <= 250; n++) begin
      if (n > 1) @(negedge clk);
      if (done1) begin
        dones++;
        if (lat_a == 0) begin lat_a = n; r_a = int'(data_out1); end
      end
      start1 = (n == 10 || n == 100 || n == 150);
    end
    start1 = 1'b0;
    check_eq("ignore/done_count", dones, 1);
    check_eq("ignore/lat", lat_a, LAT1);
    check_eq("ignore/out", r_a, 26);

    // Start held high through done: back-to-back operations
    @(negedge clk);
    start1 = 1'b1; data_in = 7'd20; exp_in = 8'd5;
    lat_a = 0; lat_b = 0; r_a = -1; r_b = -1; busy_gap = -1;
    for (int n = 1; n <= 400 && lat_b == 0; n++) begin
      @(negedge clk);
      if (n == LAT1 + 1) busy_gap = int'(busy1);
      if (done1) begin
        if (lat_a == 0) begin
          lat_a = n; r_a = int'(data_out1);
          data_in = 7'd26; exp_in = 8'd47;
        end else begin
          lat_b = n; r_b = int'(data_out1);
        end
      end
    end
    start1 = 1'b0;
    check_eq("held/lat_first", lat_a, LAT1);
    check_eq("held/out_first", r_a, 26);
    check_eq("held/busy_gap", busy_gap, 0);
    check_eq("held/lat_second", lat_b, 2 * LAT1 + 1);
    check_eq("held/out_second", r_b, 20);

    // Reset in the middle of the ladder aborts both engines
    @(negedge clk);
    start1 = 1'b1; start7 = 1'b1; data_in = 7'd20; exp_in = 8'd5;
    @(negedge clk);
    start1 = 1'b0; start7 = 1'b0;
    repeat (40) @(negedge clk);
    check_eq("midrst/busy_before", int'(busy1), 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst/data_out", int'(data_out1), 0);
    check_eq("midrst/busy", int'(busy1), 0);
    check_eq("midrst/done", int'(done1), 0);
    check_eq("midrst/err", int'(err1), 0);
    check_eq("midrst/busy_r128", int'(busy7), 0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (done1 || done7) dones++;
    end
    check_eq("midrst/no_done", dones, 0);
    do_op("post_reset", 20, 5, 26, 0);

    // Round trip over every valid message, encrypt with 5 then decrypt with 47
    for (int d = 0; d < 79; d++) begin
      c = model_pow(d, 5);
      do_op($sformatf("enc%0d", d), d, 5, c, 0);
      do_op($sformatf("dec%0d", d), c, 47, d, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
